game_binary_entry: RTL and testbench

- Reverse-direction quiz game for the 7-segment game set: the block shows a random decimal digit 1–7, and the player enters its 3-bit binary form MSB-first using two buttons ("0" and "1").
- Drives the same 4-bit `value` display code as the other games: 0–9 digit, 10 correct, 11 error, 12 blank, 13 '?'.
- Sits beside the other game modules behind the game-select mux, and takes its random source from the shared `random_digit` output.

---
 rtl/game_binary_entry_if.sv | 21 ++
 rtl/game_binary_entry.sv | 170 +++++++++++++++++
 tb/tb_game_binary_entry.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_binary_entry_if.sv
// Player-side bundle for game_binary_entry: the button and random inputs,
// plus the display and verdict outputs.
interface game_binary_entry_if;
    logic       btn0;
    logic       btn1;
    logic [3:0] rnd;
    logic [3:0] value;
    logic [2:0] entry_bits;
    logic       result_pulse;
    logic       result_ok;

    modport master (
        output btn0, btn1, rnd,
        input  value, entry_bits, result_pulse, result_ok
    );

    modport slave (
        input  btn0, btn1, rnd,
        output value, entry_bits, result_pulse, result_ok
    );
endinterface

// File: rtl/game_binary_entry.sv
// game_binary_entry: shows a random digit 1-7, and the player keys in its
// 3-bit binary form MSB-first with the "0" and "1" buttons.
// Display codes: 0-9 digit, 10 correct, 11 error, 12 blank, 13 '?'.
// Optional feature: define GAME_BINARY_ENTRY_TIMEOUT_EN to abort a round
// when no bit arrives within TIMEOUT_TIME cycles.
module game_binary_entry #(
    parameter int COUNTER_LEN  = 26,
    parameter int DELAY_TIME   = 10_000_000,
    parameter int TIMEOUT_TIME = 50_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    game_binary_entry_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_ENTRY  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    localparam logic [3:0] CODE_OK    = 4'd10;
    localparam logic [3:0] CODE_ERR   = 4'd11;
    localparam logic [3:0] CODE_BLANK = 4'd12;
    localparam logic [3:0] CODE_ASK   = 4'd13;

    localparam logic [COUNTER_LEN-1:0] DELAY_CNT = COUNTER_LEN'(DELAY_TIME);
`ifdef GAME_BINARY_ENTRY_TIMEOUT_EN
    localparam logic [COUNTER_LEN-1:0] TIMEOUT_CNT = COUNTER_LEN'(TIMEOUT_TIME);
`else
    localparam logic [COUNTER_LEN-1:0] unused_timeout_cnt = COUNTER_LEN'(TIMEOUT_TIME);
`endif

    state_t                 state, state_nx;
    logic [COUNTER_LEN-1:0] counter, counter_nx;
    logic [1:0]             bit_cnt, bit_cnt_nx;
    logic [2:0]             target, target_nx;
    logic [1:0]             btn_prev;
    logic [3:0]             value_q, value_nx;
    logic [2:0]             entry_q, entry_nx;
    logic                   pulse_q, pulse_nx;
    logic                   ok_q, ok_nx;

    logic       press0, press1, single_press, press_bit;
    logic [2:0] rnd_target;
    logic       unused_rnd_msb;

    assign press0         = bus.btn0 & ~btn_prev[0];
    assign press1         = bus.btn1 & ~btn_prev[1];
    assign single_press   = press0 ^ press1;
    assign press_bit      = press1;
    assign rnd_target     = (bus.rnd[2:0] == 3'd0) ? 3'd5 : bus.rnd[2:0];
    assign unused_rnd_msb = bus.rnd[3];

    assign bus.value        = value_q;
    assign bus.entry_bits   = entry_q;
    assign bus.result_pulse = pulse_q;
    assign bus.result_ok    = ok_q;

    // Register bank: state, counters, round data and the button edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_WAIT;
            counter  <= '0;
            bit_cnt  <= 2'd0;
            target   <= 3'd1;
            btn_prev <= 2'b11;
            value_q  <= CODE_BLANK;
            entry_q  <= 3'd0;
            pulse_q  <= 1'b0;
            ok_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            counter  <= counter_nx;
            bit_cnt  <= bit_cnt_nx;
            target   <= target_nx;
            btn_prev <= {bus.btn1, bus.btn0};
            value_q  <= value_nx;
            entry_q  <= entry_nx;
            pulse_q  <= pulse_nx;
            ok_q     <= ok_nx;
        end
    end

    // Round sequencing: next state plus the next display/verdict values.
    always_comb begin
        state_nx   = state;
        counter_nx = counter;
        bit_cnt_nx = bit_cnt;
        target_nx  = target;
        value_nx   = value_q;
        entry_nx   = entry_q;
        pulse_nx   = 1'b0;
        ok_nx      = ok_q;

        case (state)
            ST_WAIT: begin
                value_nx   = CODE_BLANK;
                counter_nx = '0;
                if (single_press) begin
                    state_nx   = ST_SHOW;
                    target_nx  = rnd_target;
                    entry_nx   = 3'd0;
                    bit_cnt_nx = 2'd0;
                    ok_nx      = 1'b0;
                    value_nx   = {1'b0, rnd_target};
                end
            end

            ST_SHOW: begin
                value_nx = {1'b0, target};
                if (counter >= DELAY_CNT) begin
                    counter_nx = '0;
                    state_nx   = ST_ENTRY;
                    value_nx   = CODE_ASK;
                end else begin
                    counter_nx = counter + 1'b1;
                end
            end

            ST_ENTRY: begin
                if (single_press) begin
                    entry_nx[2'd2 - bit_cnt] = press_bit;
                    bit_cnt_nx = bit_cnt + 1'b1;
                    value_nx   = {3'b000, press_bit};
                    counter_nx = '0;
                    if (bit_cnt == 2'd2) begin
                        ok_nx      = ({entry_q[2:1], press_bit} == target);
                        value_nx   = ({entry_q[2:1], press_bit} == target) ? CODE_OK : CODE_ERR;
                        pulse_nx   = 1'b1;
                        state_nx   = ST_RESULT;
                    end
                end
`ifdef GAME_BINARY_ENTRY_TIMEOUT_EN
                else if (counter >= TIMEOUT_CNT) begin
                    value_nx   = CODE_ERR;
                    ok_nx      = 1'b0;
                    pulse_nx   = 1'b1;
                    counter_nx = '0;
                    state_nx   = ST_RESULT;
                end else begin
                    counter_nx = counter + 1'b1;
                end
`else
                else begin
                    counter_nx = '0;
                end
`endif
            end

            ST_RESULT: begin
                if (counter >= DELAY_CNT) begin
                    counter_nx = '0;
                    state_nx   = ST_WAIT;
                    value_nx   = CODE_BLANK;
                end else begin
                    counter_nx = counter + 1'b1;
                end
            end

            default: begin
                state_nx   = ST_WAIT;
                counter_nx = '0;
                value_nx   = CODE_BLANK;
            end
        endcase
    end

endmodule

// File: tb/tb_game_binary_entry.sv
// Bench for game_binary_entry: directed rounds followed by randomized
// button activity, checked by a scoreboard of expected output changes.
module tb_game_binary_entry;

    localparam int DELAY   = 4;
    localparam int TIMEOUT = 20;

    localparam int PH_WAIT   = 0;
    localparam int PH_SHOW   = 1;
    localparam int PH_ENTRY  = 2;
    localparam int PH_RESULT = 3;

    typedef struct {
        int         cyc;
        logic [8:0] snap;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    exp_t       exp_q[$];
    logic [8:0] last_exp;
    logic [8:0] last_seen;

    // Reference model state, kept in round-level terms.
    int   m_phase;
    int   m_deadline;
    int   m_tdeadline;
    int   m_target;
    int   m_bits[$];
    bit   m_ok;
    bit   m_pulse;
    int   m_value;
    bit   m_prev0;
    bit   m_prev1;

    game_binary_entry_if bus_if ();

    game_binary_entry #(
        .COUNTER_LEN  (26),
        .DELAY_TIME   (DELAY),
        .TIMEOUT_TIME (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Edge counter shared by the driver and the monitor.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] model_snapshot();
        int entry;
        entry = 0;
        foreach (m_bits[i]) entry += m_bits[i] << (2 - i);
        return {4'(m_value), 3'(entry), m_pulse, m_ok};
    endfunction

    // Predicts what the outputs look like right after clock edge n.
    task automatic model_step(input int n, input bit b0, input bit b1,
                              input logic [3:0] r, input bit rst);
        bit   p0, p1, single;
        int   word;
        logic [8:0] snap;
        exp_t e;
        if (rst) begin
            m_phase = PH_WAIT;
            m_bits.delete();
            m_ok    = 0;
            m_pulse = 0;
            m_value = 12;
            m_target = 1;
            m_prev0 = 1;
            m_prev1 = 1;
        end else begin
            p0 = b0 && !m_prev0;
            p1 = b1 && !m_prev1;
            single = (p0 != p1);
            m_pulse = 0;
            case (m_phase)
                PH_WAIT: begin
                    if (single) begin
                        m_target = (r % 8 == 0) ? 5 : int'(r % 8);
                        m_phase = PH_SHOW;
                        m_deadline = n + DELAY + 1;
                        m_bits.delete();
                        m_ok = 0;
                        m_value = m_target;
                    end
                end
                PH_SHOW: begin
                    if (n == m_deadline) begin
                        m_phase = PH_ENTRY;
                        m_value = 13;
                        m_tdeadline = n + TIMEOUT + 1;
                    end
                end
                PH_ENTRY: begin
                    if (single) begin
                        m_bits.push_back(int'(p1));
                        m_value = int'(p1);
                        m_tdeadline = n + TIMEOUT + 1;
                        if (m_bits.size() == 3) begin
                            word = 4 * m_bits[0] + 2 * m_bits[1] + m_bits[2];
                            m_ok = (word == m_target);
                            m_value = m_ok ? 10 : 11;
                            m_pulse = 1;
                            m_phase = PH_RESULT;
                            m_deadline = n + DELAY + 1;
                        end
                    end
`ifdef GAME_BINARY_ENTRY_TIMEOUT_EN
                    else if (n == m_tdeadline) begin
                        m_value = 11;
                        m_ok = 0;
                        m_pulse = 1;
                        m_phase = PH_RESULT;
                        m_deadline = n + DELAY + 1;
                    end
`endif
                end
                default: begin
                    if (n == m_deadline) begin
                        m_phase = PH_WAIT;
                        m_value = 12;
                    end
                end
            endcase
            m_prev0 = b0;
            m_prev1 = b1;
        end
        snap = model_snapshot();
        if (snap !== last_exp) begin
            last_exp = snap;
            e.cyc = n;
            e.snap = snap;
            exp_q.push_back(e);
        end
    endtask

    // Drives one input pattern for n cycles, predicting each edge.
    task automatic applyStimulus(input bit b0, input bit b1, input logic [3:0] r,
                                 input bit rst, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus_if.btn0 = b0;
            bus_if.btn1 = b1;
            bus_if.rnd  = r;
            reset       = rst;
            model_step(cyc + 1, b0, b1, r, rst);
        end
    endtask

    task automatic pressBit(input bit b, input logic [3:0] r);
        applyStimulus(!b, b, r, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, r, 1'b0, 1);
    endtask

    // Starts a round and rides through SHOW, poking a button that must be ignored.
    task automatic startRound(input logic [3:0] r);
        applyStimulus(1'b1, 1'b0, r, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, r, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, r, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, r, 1'b0, 3);
    endtask

    // Compares one observed output change against the oldest prediction.
    task automatic checkOutput(input int n, input logic [8:0] snap);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_change cycle=%0d got value=%0d entry=%b pulse=%b ok=%b, expected no change",
                     n, snap[8:5], snap[4:2], snap[1], snap[0]);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != n || e.snap !== snap) begin
                errors++;
                $display("[TB] FAIL output_change got cycle=%0d value=%0d entry=%b pulse=%b ok=%b, expected cycle=%0d value=%0d entry=%b pulse=%b ok=%b",
                         n, snap[8:5], snap[4:2], snap[1], snap[0],
                         e.cyc, e.snap[8:5], e.snap[4:2], e.snap[1], e.snap[0]);
            end
        end
    endtask

    // Monitor: every change of the DUT outputs is handed to the scoreboard.
    always @(posedge clk) begin
        logic [8:0] snap;
        #1;
        snap = {bus_if.value, bus_if.entry_bits, bus_if.result_pulse, bus_if.result_ok};
        if (snap !== last_seen) begin
            last_seen = snap;
            checkOutput(cyc, snap);
        end
    end

    initial begin
        bit         rb0, rb1, rrst;
        logic [3:0] rr;
        checks    = 0;
        errors    = 0;
        last_exp  = 'x;
        last_seen = 'x;
        m_phase   = PH_WAIT;
        m_ok      = 0;
        m_pulse   = 0;
        m_value   = 12;
        m_target  = 1;
        m_prev0   = 1;
        m_prev1   = 1;
        reset       = 1'b1;
        bus_if.btn0 = 1'b0;
        bus_if.btn1 = 1'b1;
        bus_if.rnd  = 4'd0;

        // Reset with btn1 held; the held button must not start a round.
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b0, 4);
        applyStimulus(1'b0, 1'b0, 4'b0110, 1'b0, 3);

        // Target 6, correct entry 1,1,0.
        startRound(4'b0110);
        pressBit(1'b1, 4'd3);
        pressBit(1'b1, 4'd3);
        pressBit(1'b0, 4'd3);
        applyStimulus(1'b0, 1'b1, 4'd3, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 4'd3, 1'b0, 6);

        // rnd 1000 maps to target 5; wrong entry 1,0,0.
        startRound(4'b1000);
        pressBit(1'b1, 4'd2);
        pressBit(1'b0, 4'd2);
        pressBit(1'b0, 4'd2);
        applyStimulus(1'b0, 1'b0, 4'd2, 1'b0, 8);

        // Simultaneous press ignored; a long hold gives only one bit.
        startRound(4'b0011);
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 2);
        pressBit(1'b0, 4'd0);
        pressBit(1'b1, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 8);

        // Reset during SHOW, then during ENTRY after two bits.
        applyStimulus(1'b1, 1'b0, 4'd7, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 4'd7, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 4'd7, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 4'd7, 1'b0, 2);
        startRound(4'd1);
        pressBit(1'b0, 4'd1);
        pressBit(1'b1, 4'd1);
        applyStimulus(1'b0, 1'b0, 4'd1, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 4'd1, 1'b0, 2);
        startRound(4'd7);
        pressBit(1'b1, 4'd7);
        pressBit(1'b1, 4'd7);
        pressBit(1'b1, 4'd7);
        applyStimulus(1'b0, 1'b0, 4'd7, 1'b0, 8);

        // One bit, then a long idle: times out only when the feature is built in.
        startRound(4'd4);
        pressBit(1'b1, 4'd4);
        applyStimulus(1'b0, 1'b0, 4'd4, 1'b0, 30);
        applyStimulus(1'b0, 1'b0, 4'd4, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 4'd4, 1'b0, 2);

        // Randomized buttons, digits and rare resets.
        rb0 = 0;
        rb1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 4 == 0) rb0 = 1'($urandom % 2);
            if ($urandom % 4 == 0) rb1 = 1'($urandom % 2);
            rr   = 4'($urandom % 16);
            rrst = ($urandom % 300 == 0);
            applyStimulus(rb0, rb1, rr, rrst, 1);
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4);

        // Every prediction must have been matched by an observed change.
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover_expectations got %0d pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
